// File: rtl/mux_4_to_1.sv
// Registered (or optionally combinational) 4-to-1 lane selector.
// Latency: 1 clk when REGISTERED=1, 0 when REGISTERED=0.
// Backpressure: none; a new selection is accepted on every edge.
module mux_4_to_1 #(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4*WIDTH-1:0] in,
  input  logic [1:0]         sel,
  output logic [WIDTH-1:0]   out
);

  // Unpacked view of the four lanes; lane 0 sits at the LSBs of in.
  logic [WIDTH-1:0] lane [4];
  logic [WIDTH-1:0] picked;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane[i] = in[i*WIDTH +: WIDTH];
  end

  // Decode all four select codes; the default assignment only keeps the
  // block obviously latch-free, every code is covered explicitly.
  always_comb begin
    picked = lane[0];
    case (sel)
      2'd0: picked = lane[0];
      2'd1: picked = lane[1];
      2'd2: picked = lane[2];
      2'd3: picked = lane[3];
    endcase
  end

  if (REGISTERED) begin : g_reg
    // Output register: reset wins over data, reloaded on every edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        out <= '0;
      end else begin
        out <= picked;
      end
    end
  end else begin : g_comb
    // Glue-logic mode: no register, clk and reset intentionally unused.
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};
    assign out = picked;
  end

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed self-checking bench for mux_4_to_1 in three configurations.
// Registered narrow, registered wide, and combinational narrow instances.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_mux_4_to_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Registered, WIDTH=1
  logic       rst1;
  logic [3:0] in1;
  logic [1:0] sel1;
  logic       out1;
  // Registered, WIDTH=8
  logic        rst8;
  logic [31:0] in8;
  logic [1:0]  sel8;
  logic [7:0]  out8;
  // Combinational, WIDTH=1
  logic       rstc;
  logic [3:0] inc;
  logic [1:0] selc;
  logic       outc;

  mux_4_to_1 #(.WIDTH(1), .REGISTERED(1'b1)) dut_r1 (
    .clk(clk), .reset(rst1), .in(in1), .sel(sel1), .out(out1)
  );
  mux_4_to_1 #(.WIDTH(8), .REGISTERED(1'b1)) dut_r8 (
    .clk(clk), .reset(rst8), .in(in8), .sel(sel8), .out(out8)
  );
  mux_4_to_1 #(.WIDTH(1), .REGISTERED(1'b0)) dut_c1 (
    .clk(clk), .reset(rstc), .in(inc), .sel(selc), .out(outc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst1 = 1'b1; in1 = 4'b1111; sel1 = 2'd2;
    rst8 = 1'b1; in8 = 32'h0;   sel8 = 2'd0;
    rstc = 1'b0; inc = 4'b0100; selc = 2'd0;

    // Reset on the narrow registered instance: held for two edges.
    tick();
    check("reset_edge1", {7'b0, out1}, 8'h00);
    check("reset_w8", out8, 8'h00);
    tick();
    check("reset_edge2", {7'b0, out1}, 8'h00);
    rst1 = 1'b0;
    rst8 = 1'b0;
    tick();
    check("reset_release", {7'b0, out1}, 8'h01);

    // Walking one across every select value.
    for (int s = 0; s < 4; s++) begin
      sel1 = 2'(s);
      for (int k = 0; k < 4; k++) begin
        in1 = 4'b0001 << k;
        tick();
        check($sformatf("walk_sel%0d_bit%0d", s, k), {7'b0, out1},
              (k == s) ? 8'h01 : 8'h00);
      end
    end

    // Simultaneous sel/in change must not drop out between edges.
    sel1 = 2'd0; in1 = 4'b0001;
    tick();
    check("simul_before", {7'b0, out1}, 8'h01);
    sel1 = 2'd3; in1 = 4'b1000;
    #3;
    check("simul_between", {7'b0, out1}, 8'h01);
    tick();
    check("simul_after", {7'b0, out1}, 8'h01);
    // The new values are captured together: old lane 3 vs new lane 0.
    in1 = 4'b0111;
    tick();
    check("simul_new_lane3_zero", {7'b0, out1}, 8'h00);

    // Wide lanes, one select per cycle.
    in8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    sel8 = 2'd0; tick(); check("wide_sel0", out8, 8'hAA);
    sel8 = 2'd1; tick(); check("wide_sel1", out8, 8'hBB);
    sel8 = 2'd2; tick(); check("wide_sel2", out8, 8'hCC);
    sel8 = 2'd3; tick(); check("wide_sel3", out8, 8'hDD);

    // Mid-stream reset pulse for one edge while streaming sel=3.
    tick();
    check("midrst_pre", out8, 8'hDD);
    rst8 = 1'b1;
    tick();
    check("midrst_pulse", out8, 8'h00);
    rst8 = 1'b0;
    tick();
    check("midrst_post", out8, 8'hDD);

    // Register holds between edges even if inputs move.
    sel8 = 2'd1;
    #3;
    check("wide_hold", out8, 8'hDD);
    tick();
    check("wide_after_hold", out8, 8'hBB);

    // Combinational mode: updates without a clock edge, reset ignored.
    @(negedge clk);
    inc = 4'b0100;
    selc = 2'd0; #1; check("comb_sel0", {7'b0, outc}, 8'h00);
    selc = 2'd1; #1; check("comb_sel1", {7'b0, outc}, 8'h00);
    selc = 2'd2; #1; check("comb_sel2", {7'b0, outc}, 8'h01);
    selc = 2'd3; #1; check("comb_sel3", {7'b0, outc}, 8'h00);
    rstc = 1'b1; selc = 2'd2;
    tick();
    check("comb_reset_ignored", {7'b0, outc}, 8'h01);
    inc = 4'b1011; #1;
    check("comb_in_change", {7'b0, outc}, 8'h00);
    rstc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
